instr_fetch_rv32i: RTL and testbench

Instruction fetch stage for the RV32I core. It owns the program counter, drives the byte address into the instruction ROM (64 words, read on the falling clock edge), and captures the returned word into the IF/ID pipeline register. It also handles decode/execute stalls, branch/jump redirects with flush, and illegal fetch targets. Downstream, it feeds the decoder.

---
 rtl/instr_fetch_rv32i.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_rv32i.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_rv32i.sv
// ---------------------------------------------------------------------------
// instr_fetch_rv32i
//
// Instruction fetch stage for the RV32I core. Owns the program counter,
// addresses the instruction ROM (read on the falling clock edge) and captures
// the returned word into the IF/ID pipeline register. Handles downstream
// stalls, branch/jump redirects with flush, and illegal fetch targets.
//
// Ports:
//   clock        in   system clock, all state updates on the rising edge
//   reset_n      in   asynchronous active-low reset
//   PC           out  current fetch byte address (drives the ROM)
//   INSTR        in   ROM read data for PC
//   STALL        in   downstream cannot accept an instruction this cycle
//   REDIRECT     in   taken branch / jump, load REDIRECT_PC
//   REDIRECT_PC  in   redirect target byte address
//   IFID_VALID   out  IF/ID slot holds a real instruction
//   IFID_INSTR   out  fetched instruction (NOP_INSTR when empty)
//   IFID_PC      out  address of IFID_INSTR
//   IFID_PC4     out  IFID_PC + 4
//   FAULT        out  sticky illegal-fetch flag
//   FAULT_PC     out  offending target address
//   FETCH_COUNT  out  number of instructions delivered into IF/ID
// ---------------------------------------------------------------------------
module instr_fetch_rv32i #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 64,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] PC,
    input  logic [31:0] INSTR,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IFID_VALID,
    output logic [31:0] IFID_INSTR,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic        FAULT,
    output logic [31:0] FAULT_PC,
    output logic [31:0] FETCH_COUNT
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Size of the ROM in bytes, kept 33 bits wide so the comparison below
    // also sees the carry out of PC+4.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        ifid_valid_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pc4_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;
    logic [31:0] fetch_count_q;

    // A target is fetchable when word aligned and inside the ROM. The
    // argument is 33 bits so an address that wrapped past 2^32 is rejected.
    function automatic logic is_legal(input logic [32:0] addr);
        return (addr[1:0] == 2'b00) && (addr < IMEM_BYTES);
    endfunction

    logic [32:0] pc_plus4_wide;
    logic [31:0] pc_plus4;
    logic        seq_legal;
    logic        redirect_legal;

    assign pc_plus4_wide  = {1'b0, pc_q} + 33'd4;
    assign pc_plus4       = pc_plus4_wide[31:0];
    assign seq_legal      = is_legal(pc_plus4_wide);
    assign redirect_legal = is_legal({1'b0, REDIRECT_PC});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= 32'h0;
            ifid_pc4_q    <= 32'h0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            case (state_q)
                // One idle cycle so the ROM has completed a falling-edge
                // read of RESET_VECTOR before the first capture.
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (REDIRECT) begin
                        // Redirect wins over stall; the slot is flushed so
                        // exactly one bubble precedes the target.
                        ifid_valid_q <= 1'b0;
                        ifid_instr_q <= NOP_INSTR;
                        if (redirect_legal) begin
                            pc_q <= REDIRECT_PC;
                        end else begin
                            state_q    <= ST_FAULT;
                            fault_q    <= 1'b1;
                            fault_pc_q <= REDIRECT_PC;
                        end
                    end else if (!STALL) begin
                        ifid_valid_q  <= 1'b1;
                        ifid_instr_q  <= INSTR;
                        ifid_pc_q     <= pc_q;
                        ifid_pc4_q    <= pc_plus4;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        if (seq_legal) begin
                            pc_q <= pc_plus4;
                        end else begin
                            // Running off the end of the ROM: the word just
                            // captured is still delivered, PC stays put.
                            state_q    <= ST_FAULT;
                            fault_q    <= 1'b1;
                            fault_pc_q <= pc_plus4;
                        end
                    end
                end

                // Terminal until reset. Clearing every cycle lets a word
                // captured on the faulting edge live for exactly one cycle.
                ST_FAULT: begin
                    ifid_valid_q <= 1'b0;
                    ifid_instr_q <= NOP_INSTR;
                end

                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign IFID_VALID  = ifid_valid_q;
    assign IFID_INSTR  = ifid_instr_q;
    assign IFID_PC     = ifid_pc_q;
    assign IFID_PC4    = ifid_pc4_q;
    assign FAULT       = fault_q;
    assign FAULT_PC    = fault_pc_q;
    assign FETCH_COUNT = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_rv32i.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_rv32i
//
// Directed bench for instr_fetch_rv32i. A ROM holding word i = 0x1000_0000+i
// answers PC on every falling edge. A behavioural model of the fetch stage
// tracks the expected outputs; they are compared at every falling edge, and
// the directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_instr_fetch_rv32i;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset_n;
    logic [31:0] PC;
    logic [31:0] INSTR;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IFID_VALID;
    logic [31:0] IFID_INSTR;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_PC4;
    logic        FAULT;
    logic [31:0] FAULT_PC;
    logic [31:0] FETCH_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_rv32i #(
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_WORDS  (64),
        .NOP_INSTR   (NOP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .PC         (PC),
        .INSTR      (INSTR),
        .STALL      (STALL),
        .REDIRECT   (REDIRECT),
        .REDIRECT_PC(REDIRECT_PC),
        .IFID_VALID (IFID_VALID),
        .IFID_INSTR (IFID_INSTR),
        .IFID_PC    (IFID_PC),
        .IFID_PC4   (IFID_PC4),
        .FAULT      (FAULT),
        .FAULT_PC   (FAULT_PC),
        .FETCH_COUNT(FETCH_COUNT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents as a formula: word at byte address a is 0x1000_0000 + a/4.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        if (addr < 32'd256) return 32'h1000_0000 + (addr >> 2);
        return 32'h0;
    endfunction

    // ROM read port: samples PC on the falling edge.
    initial INSTR = 32'h0;
    always @(negedge clock) INSTR = rom_word(PC);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the fetch rules written as plain arithmetic.
    // ------------------------------------------------------------------
    typedef struct {
        int          phase;   // 0 boot, 1 running, 2 faulted
        logic [31:0] pc;
        bit          v;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        bit          f;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } mstate_t;

    mstate_t m;

    function automatic bit legal(input longint a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    function automatic mstate_t reset_m();
        mstate_t r;
        r.phase = 0; r.pc = 32'h0; r.v = 0; r.ins = NOP; r.ipc = 32'h0;
        r.ipc4 = 32'h0; r.f = 0; r.fpc = 32'h0; r.cnt = 32'h0;
        return r;
    endfunction

    function automatic mstate_t step_m(input mstate_t s, input bit stall,
                                       input bit redir, input logic [31:0] rpc);
        mstate_t r = s;
        longint  nxt;
        if (s.phase == 0) begin
            r.phase = 1;
        end else if (s.phase == 2) begin
            r.v = 0; r.ins = NOP;
        end else if (redir) begin
            r.v = 0; r.ins = NOP;
            if (legal(longint'(rpc))) r.pc = rpc;
            else begin r.phase = 2; r.f = 1; r.fpc = rpc; end
        end else if (!stall) begin
            nxt    = longint'(s.pc) + 4;
            r.v    = 1;
            r.ins  = rom_word(s.pc);
            r.ipc  = s.pc;
            r.ipc4 = 32'(nxt);
            r.cnt  = s.cnt + 1;
            if (legal(nxt)) r.pc = 32'(nxt);
            else begin r.phase = 2; r.f = 1; r.fpc = 32'(nxt); end
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= reset_m();
        else          m <= step_m(m, STALL, REDIRECT, REDIRECT_PC);
    end

    // Single compare process: every falling edge once reset has been seen.
    bit model_live = 0;
    always @(negedge clock) begin
        if (model_live) begin
            chk("cmp_PC",          PC,                  m.pc);
            chk("cmp_IFID_VALID",  {31'h0, IFID_VALID}, {31'h0, m.v});
            chk("cmp_IFID_INSTR",  IFID_INSTR,          m.ins);
            chk("cmp_IFID_PC",     IFID_PC,             m.ipc);
            chk("cmp_IFID_PC4",    IFID_PC4,            m.ipc4);
            chk("cmp_FAULT",       {31'h0, FAULT},      {31'h0, m.f});
            chk("cmp_FAULT_PC",    FAULT_PC,            m.fpc);
            chk("cmp_FETCH_COUNT", FETCH_COUNT,         m.cnt);
            if (IFID_VALID)
                $display("t=%0t IFID_PC=%h IFID_INSTR=%h count=%0d",
                         $time, IFID_PC, IFID_INSTR, FETCH_COUNT);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_PC"},    PC,                  32'h0);
        chk({tag, "_VALID"}, {31'h0, IFID_VALID}, 32'h0);
        chk({tag, "_INSTR"}, IFID_INSTR,          NOP);
        chk({tag, "_IPC"},   IFID_PC,             32'h0);
        chk({tag, "_IPC4"},  IFID_PC4,            32'h0);
        chk({tag, "_FAULT"}, {31'h0, FAULT},      32'h0);
        chk({tag, "_FPC"},   FAULT_PC,            32'h0);
        chk({tag, "_CNT"},   FETCH_COUNT,         32'h0);
    endtask

    // Reset asserted between edges, released on a falling edge, then the
    // BOOT bubble and the first capture from address 0.
    task automatic reset_and_boot();
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("boot_valid", {31'h0, IFID_VALID}, 32'h0);
        chk("boot_pc", PC, 32'h0);
        tick();
        chk("first_ipc", IFID_PC, 32'h0);
        chk("first_instr", IFID_INSTR, 32'h1000_0000);
        chk("first_cnt", FETCH_COUNT, 32'd1);
    endtask

    initial begin
        reset_n     = 1'b1;
        STALL       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        #1;
        reset_n = 1'b0;
        #2;
        chk_reset_vals("por");
        model_live = 1;
        @(negedge clock);
        reset_n = 1'b1;

        // BOOT bubble
        tick();
        chk("boot_valid", {31'h0, IFID_VALID}, 32'h0);
        chk("boot_pc", PC, 32'h0);

        // Free-run: IFID_PC 0,4,8
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("run_ipc", IFID_PC, 32'(4 * k));
            chk("run_instr", IFID_INSTR, 32'h1000_0000 + 32'(k));
            chk("run_valid", {31'h0, IFID_VALID}, 32'h1);
        end

        // Stall hold while IFID_PC = 8
        STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ipc", IFID_PC, 32'h8);
            chk("stall_instr", IFID_INSTR, 32'h1000_0002);
            chk("stall_pc", PC, 32'hC);
            chk("stall_cnt", FETCH_COUNT, 32'd3);
        end
        STALL = 1'b0;
        tick();
        chk("post_stall_ipc", IFID_PC, 32'hC);
        chk("post_stall_instr", IFID_INSTR, 32'h1000_0003);
        chk("post_stall_cnt", FETCH_COUNT, 32'd4);

        // Redirect while stalled
        STALL       = 1'b1;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h40;
        tick();
        chk("redir_valid", {31'h0, IFID_VALID}, 32'h0);
        chk("redir_instr", IFID_INSTR, NOP);
        chk("redir_pc", PC, 32'h40);
        STALL    = 1'b0;
        REDIRECT = 1'b0;
        tick();
        chk("redir_tgt_ipc", IFID_PC, 32'h40);
        chk("redir_tgt_instr", IFID_INSTR, 32'h1000_0010);
        chk("redir_tgt_valid", {31'h0, IFID_VALID}, 32'h1);
        tick();
        tick();
        chk("pre_rst_cnt", FETCH_COUNT, 32'd7);
        chk("pre_rst_ipc", IFID_PC, 32'h48);

        // Asynchronous reset mid-run, then restart
        reset_and_boot();

        // End of ROM
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFC;
        tick();
        chk("eor_pc", PC, 32'hFC);
        REDIRECT = 1'b0;
        tick();
        chk("eor_valid", {31'h0, IFID_VALID}, 32'h1);
        chk("eor_ipc", IFID_PC, 32'hFC);
        chk("eor_ipc4", IFID_PC4, 32'h100);
        chk("eor_instr", IFID_INSTR, 32'h1000_003F);
        chk("eor_fault", {31'h0, FAULT}, 32'h1);
        chk("eor_fpc", FAULT_PC, 32'h100);
        chk("eor_pc_hold", PC, 32'hFC);
        tick();
        chk("eor_clear_valid", {31'h0, IFID_VALID}, 32'h0);
        chk("eor_clear_instr", IFID_INSTR, NOP);

        // Misaligned redirect
        reset_and_boot();
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h42;
        tick();
        chk("mis_fault", {31'h0, FAULT}, 32'h1);
        chk("mis_fpc", FAULT_PC, 32'h42);
        chk("mis_valid", {31'h0, IFID_VALID}, 32'h0);
        chk("mis_pc", PC, 32'h4);
        for (int k = 0; k < 12; k++) begin
            STALL       = 1'($urandom_range(1));
            REDIRECT    = 1'($urandom_range(1));
            REDIRECT_PC = 32'($urandom_range(63)) << 2;
            tick();
            chk("frz_pc", PC, 32'h4);
            chk("frz_valid", {31'h0, IFID_VALID}, 32'h0);
            chk("frz_fault", {31'h0, FAULT}, 32'h1);
            chk("frz_fpc", FAULT_PC, 32'h42);
        end
        STALL    = 1'b0;
        REDIRECT = 1'b0;
        @(negedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
